// File: rtl/mem_access_stage_if.sv
// Bundles the EX_MEM inputs, the data-memory req/ack port and the MEM_WB outputs of the MEM stage.
interface mem_access_stage_if;
  // EX_MEM side
  logic        MemRead_i;
  logic        MemWrite_i;
  logic        RegWrite_i;
  logic        MemtoReg_i;
  logic [31:0] ALU_result_i;
  logic [31:0] wrData_i;
  logic [4:0]  RDaddr_i;
  // data-memory port
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  // MEM_WB side and pipeline control
  logic        RegWrite_o;
  logic        MemtoReg_o;
  logic [31:0] dataMem_data_o;
  logic [31:0] ALU_result_o;
  logic [4:0]  RDaddr_o;
  logic        stall_o;
  logic        err_o;

  // Stage side: consumes EX_MEM and memory responses, drives requests and MEM_WB.
  modport master (
    input  MemRead_i, MemWrite_i, RegWrite_i, MemtoReg_i, ALU_result_i, wrData_i, RDaddr_i,
    input  mem_ack_i, mem_rdata_i,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output RegWrite_o, MemtoReg_o, dataMem_data_o, ALU_result_o, RDaddr_o, stall_o, err_o
  );

  // Environment side: pipeline registers and memory model.
  modport slave (
    output MemRead_i, MemWrite_i, RegWrite_i, MemtoReg_i, ALU_result_i, wrData_i, RDaddr_i,
    output mem_ack_i, mem_rdata_i,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  RegWrite_o, MemtoReg_o, dataMem_data_o, ALU_result_o, RDaddr_o, stall_o, err_o
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM-stage data-memory access unit: runs lw/sw over a variable-latency req/ack port,
// stalls the front of the pipe while busy and hands MEM_WB one completed result.
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input logic                  clk_i,
  input logic                  rst_i,
  mem_access_stage_if.master   bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   waitCnt;
  logic               latRegWrite;
  logic               latMemtoReg;
  logic [31:0]        latAlu;
  logic [4:0]         latRd;
  logic [31:0]        latData;
  logic               memReq;
  logic               memWe;
  logic [31:0]        memAddr;
  logic [31:0]        memWdata;
  logic               errFlag;

  logic               memOp;
  logic               regWriteOut;
  logic               memtoRegOut;
  logic [31:0]        dataOut;
  logic [31:0]        aluOut;
  logic [4:0]         rdOut;
  logic               stallOut;

  assign memOp = bus.MemRead_i | bus.MemWrite_i;

  // Access sequencer: latches the instruction, drives the memory port and tracks timeout/error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      waitCnt     <= '0;
      latRegWrite <= 1'b0;
      latMemtoReg <= 1'b0;
      latAlu      <= '0;
      latRd       <= '0;
      latData     <= '0;
      memReq      <= 1'b0;
      memWe       <= 1'b0;
      memAddr     <= '0;
      memWdata    <= '0;
      errFlag     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (memOp) begin
            latRegWrite <= bus.RegWrite_i;
            latMemtoReg <= bus.MemtoReg_i;
            latAlu      <= bus.ALU_result_i;
            latRd       <= bus.RDaddr_i;
            latData     <= '0;
            memReq      <= 1'b1;
            memWe       <= bus.MemWrite_i;
            memAddr     <= {bus.ALU_result_i[31:2], 2'b00};
            memWdata    <= bus.wrData_i;
            waitCnt     <= '0;
            // misaligned address is flagged but the word access still goes out
            if (bus.ALU_result_i[1:0] != 2'b00) errFlag <= 1'b1;
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          if (bus.mem_ack_i) begin
            latData <= memWe ? 32'h0 : bus.mem_rdata_i;
            memReq  <= 1'b0;
            state   <= DONE;
          end else if (waitCnt == CNT_W'(TIMEOUT - 1)) begin
            latData <= '0;
            memReq  <= 1'b0;
            errFlag <= 1'b1;
            state   <= DONE;
          end else begin
            waitCnt <= waitCnt + CNT_W'(1);
          end
        end
        // EX_MEM still shows the same instruction here, so never re-trigger from DONE
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // MEM_WB view: pass-through when idle, bubble while busy, latched result for one DONE cycle.
  always_comb begin
    regWriteOut = 1'b0;
    memtoRegOut = 1'b0;
    dataOut     = '0;
    aluOut      = '0;
    rdOut       = '0;
    stallOut    = 1'b0;
    case (state)
      IDLE: begin
        if (memOp) begin
          stallOut = 1'b1;
        end else begin
          regWriteOut = bus.RegWrite_i;
          memtoRegOut = bus.MemtoReg_i;
          aluOut      = bus.ALU_result_i;
          rdOut       = bus.RDaddr_i;
        end
      end
      ACCESS: stallOut = 1'b1;
      DONE: begin
        regWriteOut = latRegWrite;
        memtoRegOut = latMemtoReg;
        dataOut     = latData;
        aluOut      = latAlu;
        rdOut       = latRd;
      end
      default: stallOut = 1'b0;
    endcase
  end

  assign bus.mem_req_o      = memReq;
  assign bus.mem_we_o       = memWe;
  assign bus.mem_addr_o     = memAddr;
  assign bus.mem_wdata_o    = memWdata;
  assign bus.err_o          = errFlag;
  assign bus.RegWrite_o     = regWriteOut;
  assign bus.MemtoReg_o     = memtoRegOut;
  assign bus.dataMem_data_o = dataOut;
  assign bus.ALU_result_o   = aluOut;
  assign bus.RDaddr_o       = rdOut;
  assign bus.stall_o        = stallOut;

endmodule
